// File: rtl/filter_pkg.sv
// Shared constants for the half-band filter chain
// and its decimating requantiser output stage.
package filter_pkg;

    localparam int OUTPUT_SAMPLE_DATA_WIDTH = 20;
    localparam int MAX_NOF_SAMPLES          = 4096;

    localparam int DEC_FACTOR     = 2;
    localparam int REQ_OUT_WIDTH  = 12;
    localparam int REQ_SHIFT      = 8;
    localparam int OUT_FIFO_DEPTH = 8;

endpackage

// File: rtl/hbf_dec_requant_if.sv
// Valid/ready sample stream from the requantiser
// to its consumer.
interface hbf_dec_requant_if #(
    parameter int W = 12
) ();

    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word;
// accepts a write when full if a read happens too.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    rnext;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             do_wr, do_rd;

    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign dout  = dout_q;
    assign do_rd = rd_en & ~empty;
    assign do_wr = wr_en & (~full | do_rd);
    assign rnext = rptr_q + AW'(1);

    // Pointer/count update and next head word selection.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (do_wr) wptr_d = wptr_q + AW'(1);
        if (do_rd) rptr_d = rnext;
        unique case ({do_wr, do_rd})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        // An incoming word becomes the head when the FIFO
        // is (or is about to become) empty.
        if (do_wr && (empty || (cnt_q == CNT_ONE && do_rd))) begin
            dout_d = din;
        end else if (do_rd && cnt_q > CNT_ONE) begin
            dout_d = mem_q[rnext];
        end
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            dout_d = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/hbf_dec_requant.sv
// Decimate-by-2, round/saturate and buffer the
// half-band filter output stream.
module hbf_dec_requant
    import filter_pkg::*;
#(
    parameter int IN_W        = OUTPUT_SAMPLE_DATA_WIDTH,
    parameter int OUT_W       = REQ_OUT_WIDTH,
    parameter int SHIFT       = REQ_SHIFT,
    parameter int FIFO_DEPTH  = OUT_FIFO_DEPTH,
    parameter int NOF_SAMPLES = MAX_NOF_SAMPLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            phase_i,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    hbf_dec_requant_if.master out_if,
    output logic            sat_flag,
    output logic            ovf_flag,
    output logic            frame_done
);

    localparam int SUM_W   = IN_W + 1;
    localparam int Q_W     = SUM_W - SHIFT;
    localparam int OUT_FRM = NOF_SAMPLES / DEC_FACTOR;
    localparam int CNT_W   = $clog2(OUT_FRM);

    localparam logic signed [SUM_W-1:0] RND =
        SUM_W'(2 ** (SHIFT - 1));
    localparam logic signed [Q_W-1:0] Q_MAX =
        Q_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [Q_W-1:0] Q_MIN =
        Q_W'(-(2 ** (OUT_W - 1)));
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(OUT_FRM - 1);

    logic                    par_q, par_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [OUT_W-1:0]        s1_data_q, s1_data_d;
    logic                    sat_q, sat_d;
    logic                    ovf_q, ovf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    fd_q, fd_d;

    logic signed [SUM_W-1:0] sum;
    logic signed [Q_W-1:0]   q;
    logic [OUT_W-1:0]        q_sat;
    logic                    sat;
    logic                    keep;
    logic                    rd;
    logic                    full;
    logic                    empty;
    logic [OUT_W-1:0]        head;

    assign keep = in_valid & (par_q == phase_i);
    assign rd   = out_if.valid & out_if.ready;

    assign out_if.valid = ~empty;
    assign out_if.data  = head;
    assign sat_flag     = sat_q;
    assign ovf_flag     = ovf_q;
    assign frame_done   = fd_q;

    // Round half-up, drop SHIFT LSBs, clamp to OUT_W.
    always_comb begin
        sum   = $signed({in_data[IN_W-1], in_data}) + RND;
        q     = Q_W'(sum >>> SHIFT);
        sat   = 1'b0;
        q_sat = q[OUT_W-1:0];
        if (q > Q_MAX) begin
            q_sat = Q_MAX[OUT_W-1:0];
            sat   = 1'b1;
        end else if (q < Q_MIN) begin
            q_sat = Q_MIN[OUT_W-1:0];
            sat   = 1'b1;
        end
    end

    // Next state: parity, stage S1, flags, frame counter.
    always_comb begin
        par_d      = par_q;
        s1_valid_d = keep;
        s1_data_d  = q_sat;
        sat_d      = sat_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        fd_d       = 1'b0;
        if (in_valid) par_d = ~par_q;
        if (keep && sat) sat_d = 1'b1;
        if (s1_valid_q && full && !rd) ovf_d = 1'b1;
        if (rd) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                fd_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (clr) begin
            par_d      = 1'b0;
            s1_valid_d = 1'b0;
            sat_d      = 1'b0;
            ovf_d      = 1'b0;
            cnt_d      = '0;
            fd_d       = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            sat_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            fd_q       <= 1'b0;
        end else begin
            par_q      <= par_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            fd_q       <= fd_d;
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .wr_en (s1_valid_q),
        .din   (s1_data_q),
        .rd_en (rd),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_hbf_dec_requant.sv
// Directed scoreboard bench for the decimating
// requantiser output stage.
module tb_hbf_dec_requant;

    localparam int NOF = 16;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        clr      = 1'b0;
    logic        phase    = 1'b0;
    logic        in_valid = 1'b0;
    logic [19:0] in_data  = '0;
    logic        ready    = 1'b0;
    logic        sat_flag;
    logic        ovf_flag;
    logic        frame_done;

    int          tests = 0;
    int          fails = 0;
    logic [11:0] sb[$];
    bit          mpar = 1'b0;
    int          hs_cnt = 0;
    int          fd_cnt = 0;
    int          fd_hs = 0;
    bit          last_hs = 1'b0;
    bit          fd_prev_hs = 1'b0;
    int          h0, f0;

    hbf_dec_requant_if #(.W(12)) out_if ();

    assign out_if.ready = ready;

    hbf_dec_requant #(
        .IN_W        (20),
        .OUT_W       (12),
        .SHIFT       (8),
        .FIFO_DEPTH  (8),
        .NOF_SAMPLES (NOF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .phase_i    (phase),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_if     (out_if),
        .sat_flag   (sat_flag),
        .ovf_flag   (ovf_flag),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic void check(string tag, logic [31:0] obs,
                                  logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endfunction

    function automatic logic [11:0] model(logic [19:0] x);
        int v;
        v = int'($signed(x));
        v = (v + 128) >>> 8;
        if (v > 2047) v = 2047;
        if (v < -2048) v = -2048;
        return v[11:0];
    endfunction

    // Output monitor: pops scoreboard on handshakes,
    // records frame_done timing.
    always @(negedge clk) begin
        if (rst_n && !clr) begin
            if (frame_done) begin
                fd_cnt++;
                fd_hs = hs_cnt;
                fd_prev_hs = last_hs;
            end
            last_hs = out_if.valid && ready;
            if (out_if.valid && ready) begin
                hs_cnt++;
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0)
                    check("out_data", 32'(out_if.data),
                          32'(sb.pop_front()));
            end
        end else begin
            last_hs = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [19:0] x, input bit push_ok);
        in_valid = 1'b1;
        in_data  = x;
        if (mpar == phase && push_ok) sb.push_back(model(x));
        mpar = ~mpar;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mpar = 1'b0;
    endtask

    task automatic drain(string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 32'(n < 300), 1);
        repeat (3) tick();
        check({tag, "_empty"}, 32'(out_if.valid), 0);
    endtask

    initial begin
        repeat (2) tick();
        check("rst_out_valid", 32'(out_if.valid), 0);
        check("rst_out_data", 32'(out_if.data), 0);
        check("rst_sat", 32'(sat_flag), 0);
        check("rst_ovf", 32'(ovf_flag), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        rst_n = 1'b1;
        tick();

        // Rounding: expect 1, 0, 1, -1
        ready = 1'b1;
        phase = 1'b0;
        send(20'd128, 1);   send(20'd0, 1);
        send(20'hFFF80, 1); send(20'd0, 1);
        send(20'd383, 1);   send(20'd0, 1);
        send(20'hFFF7F, 1); send(20'd0, 1);
        drain("round");
        check("round_sat", 32'(sat_flag), 0);
        check("round_ovf", 32'(ovf_flag), 0);

        // Saturation at both rails
        send(20'h7FFFF, 1); send(20'd0, 1);
        drain("sat_hi");
        check("sat_hi_flag", 32'(sat_flag), 1);
        do_clr();
        check("clr_sat", 32'(sat_flag), 0);
        send(20'h80000, 1); send(20'd0, 1);
        drain("sat_lo");
        check("sat_lo_flag", 32'(sat_flag), 0);

        // Phase selection
        phase = 1'b1;
        for (int k = 0; k < 10; k++) send(20'(k * 256), 1);
        drain("phase1");
        phase = 1'b0;
        for (int k = 0; k < 10; k++) send(20'(k * 256), 1);
        drain("phase0");

        // Overflow: 10 kept, 8 stored
        do_clr();
        ready = 1'b0;
        for (int k = 0; k < 20; k++)
            send(20'((k + 1) * 256), k < 16);
        repeat (3) tick();
        check("ovf_set", 32'(ovf_flag), 1);
        check("ovf_valid", 32'(out_if.valid), 1);
        check("ovf_head", 32'(out_if.data), 1);
        repeat (4) tick();
        check("ovf_head_stable", 32'(out_if.data), 1);
        ready = 1'b1;
        drain("ovf");
        check("ovf_sticky", 32'(ovf_flag), 1);

        // Full with simultaneous read and write
        do_clr();
        ready = 1'b0;
        for (int k = 0; k < 18; k++) begin
            if (k == 17) ready = 1'b1;
            send(20'((k + 1) * 256), 1);
        end
        drain("full_rw");
        check("full_rw_ovf", 32'(ovf_flag), 0);

        // Frame completion, two frames
        do_clr();
        ready = 1'b1;
        h0 = hs_cnt;
        f0 = fd_cnt;
        for (int k = 0; k < 16; k++)
            send(20'((k * 300) - 2000), 1);
        drain("frame1");
        check("frame1_pulses", 32'(fd_cnt - f0), 1);
        check("frame1_hs", 32'(fd_hs - h0), 8);
        check("frame1_lag", 32'(fd_prev_hs), 1);
        for (int k = 0; k < 16; k++)
            send(20'(k * 512), 1);
        drain("frame2");
        check("frame2_pulses", 32'(fd_cnt - f0), 2);
        check("frame2_hs", 32'(fd_hs - h0), 16);

        // Asynchronous reset with 5 entries queued
        ready = 1'b0;
        send(20'h7FFFF, 0);
        for (int k = 1; k < 9; k++) send(20'(k * 256), 0);
        repeat (3) tick();
        check("pre_rst_valid", 32'(out_if.valid), 1);
        check("pre_rst_sat", 32'(sat_flag), 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_if.valid), 0);
        check("arst_data", 32'(out_if.data), 0);
        check("arst_sat", 32'(sat_flag), 0);
        check("arst_ovf", 32'(ovf_flag), 0);
        tick();
        rst_n = 1'b1;
        mpar = 1'b0;
        ready = 1'b1;
        send(20'd256, 1); send(20'd512, 1);
        drain("post_rst");

        // Synchronous clear mid-stream, input ignored
        ready = 1'b0;
        send(20'h7FFFF, 0);
        for (int k = 1; k < 9; k++) send(20'(k * 256), 0);
        repeat (3) tick();
        check("pre_clr_valid", 32'(out_if.valid), 1);
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = 20'h7FFFF;
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        mpar = 1'b0;
        check("clr_valid", 32'(out_if.valid), 0);
        check("clr_sat2", 32'(sat_flag), 0);
        check("clr_ovf", 32'(ovf_flag), 0);
        tick();
        check("clr_in_ignored", 32'(out_if.valid), 0);
        ready = 1'b1;
        send(20'd768, 1); send(20'd1024, 1);
        drain("post_clr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
